uart_rx_16x: RTL
================

# uart_rx_16x

UART receive front end that consumes the single-cycle `baud_tick_16x` strobe from the baud generator. It oversamples the serial line at 16x and validates the start bit at mid-bit. It shifts in data LSB-first, checks the stop bit, and presents each received character in a one-entry holding register with a valid/ready handshake to the downstream consumer.

## Interface
- `DATA_BITS`, 8: data bits per frame (5–8); no parity; one stop bit.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `baud_tick_16x`  input  1  one-clock pulse at 16x the baud rate, from the baud generator; at least 2 clocks between pulses.
- `rx`  input  1  asynchronous serial line; idle high.
- `rx_ready`  input  1  consumer pop; takes effect only while `rx_valid`=1.
- `rx_data`  output  DATA_BITS  received character; stable while `rx_valid`=1.
- `rx_valid`  output  1  holding register full.
- `framing_err`  output  1  one-clock pulse when the stop bit samples low.
- `overrun_err`  output  1  one-clock pulse when a good frame completes while the register is still full.
- `busy`  output  1  high in every state except IDLE.

## Operation
- **Synchronizer**
  - `rx` passes through 2 flops, giving `rx_s`; both flops reset to 1.
  - All sampling uses `rx_s`.
- **Counters**
  - `tick_cnt` is 4 bits.
  - `bit_cnt` is `clog2(DATA_BITS)` bits.
  - Counters advance only on clocks where `baud_tick_16x`=1; nothing changes on other clocks.
- **State machine** (state names IDLE, START, DATA, STOP):
  - IDLE: on a tick with `rx_s`=0, go to START with `tick_cnt`=0.
  - START: on each tick, increment `tick_cnt`. On the tick where `tick_cnt`==7 (mid start bit):
    - `rx_s`=0: go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
    - `rx_s`=1: false start; return to IDLE with no output.
  - DATA: on each tick, increment `tick_cnt`. On the tick where `tick_cnt`==15:
    - shift `rx_s` into the MSB of the shift register (LSB-first line order);
    - set `tick_cnt`=0 and increment `bit_cnt`;
    - after the sample with `bit_cnt`==DATA_BITS-1, go to STOP.
  - STOP: on the tick where `tick_cnt`==15, sample `rx_s` and return to IDLE.
    - `rx_s`=1: good frame; deliver to the holding register.
    - `rx_s`=0: pulse `framing_err`; discard the data.
- **Holding register**
  - A good frame with `rx_valid`=0 loads `rx_data` and sets `rx_valid`.
  - A good frame with `rx_valid`=1 and `rx_ready`=1 in the same clock loads the new data; `rx_valid` stays 1.
  - A good frame with `rx_valid`=1 and `rx_ready`=0 keeps the old data, drops the new frame, and pulses `overrun_err`.
  - `rx_ready`=1 with `rx_valid`=1 and no load clears `rx_valid` at the next edge.
  - `rx_ready` while `rx_valid`=0 is ignored.
- **Arithmetic**: `tick_cnt` never exceeds 15. `bit_cnt` saturates at DATA_BITS-1 and never wraps inside a frame.

## Timing
- **Reset values**:
  - state IDLE; counters 0; shift register 0;
  - `rx_data`=0, `rx_valid`=0, `framing_err`=0, `overrun_err`=0, `busy`=0.
- **Reset mid-frame**: on the next edge the block is in IDLE with the reset values above, and the partial frame is lost. It resynchronizes on the next falling edge of `rx_s`.
- **Input latency**: the synchronizer adds 2 clocks from `rx` to `rx_s`.
- **Start detection**: happens on the first tick after `rx_s` falls, so the detection edge lags the true falling edge by up to one tick period.
- **Sample point**: each data and stop bit is sampled 16 ticks after the previous sample, which lands near mid-bit.
- **Output timing**:
  - `rx_valid` rises one clock after the stop-bit sampling tick.
  - `framing_err` and `overrun_err` are high for exactly that same clock.
- **Frame duration**: from the start-detection tick back to IDLE takes 8 + 16·DATA_BITS + 16 ticks. The block re-arms at mid stop bit, so back-to-back frames with no idle gap are received.
- **Line held low**: after a framing error, if the line stays low, IDLE re-enters START on the next tick.

## Test plan
- **Single frame**: baud generator with tick every 6 clocks (bit = 96 clocks); send 0xA5 (8N1) -> `rx_data`=0xA5, `rx_valid`=1, no error pulses.
- **Back-to-back frames**: 0x00 then 0xFF with zero idle gap, popping after each -> two deliveries, 0x00 then 0xFF.
- **False start**: low glitch of 3 ticks (18 clocks) on idle line -> returns to IDLE, `rx_valid` stays 0, `busy` falls after the tick-7 check.
- **Framing error**: send 0x3C with stop bit forced low -> `framing_err` pulses once, `rx_valid` stays 0, `rx_data` unchanged.
- **Overrun and simultaneous pop**:
  - send 0x11 and 0x22 with no pop -> `rx_data`=0x11, one `overrun_err` pulse;
  - repeat with `rx_ready` asserted on the load clock -> `rx_data`=0x22, `rx_valid` stays 1.
- **Reset mid-frame**: assert `rst` for 1 clock during bit 4 of 0x5A -> all outputs at reset values; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_16x.sv
// -----------------------------------------------------------------------------
// uart_rx_16x
//
// UART receive front end driven by a 16x oversampling strobe from an external
// baud generator. The line is synchronized, the start bit is validated at its
// middle, DATA_BITS data bits are shifted in LSB-first, and the stop bit is
// checked. Good characters land in a one-entry holding register that the
// consumer drains with a valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   baud_tick_16x one-clock strobe at 16x the baud rate
//   rx            asynchronous serial input, idle high
//   rx_ready      consumer pop, honoured only while rx_valid is high
//   rx_data       received character, stable while rx_valid is high
//   rx_valid      holding register full
//   framing_err   one-clock pulse when the stop bit samples low
//   overrun_err   one-clock pulse when a good frame is dropped (register full)
//   busy          receiver is anywhere but IDLE
// -----------------------------------------------------------------------------
module uart_rx_16x #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_16x,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int             BCW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                 sync1_q;
    logic                 rx_s_q;
    state_t               state_q, state_d;
    logic [3:0]           tick_q,  tick_d;
    logic [BCW-1:0]       bit_q,   bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q,  ferr_d;
    logic                 ovr_q,   ovr_d;
    logic                 frame_good;
    logic                 frame_bad;
    logic                 load;

    // Registers (two-flop synchronizer resets to the idle line level)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Receive state machine: everything advances only on oversampling ticks
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;

        if (baud_tick_16x) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    tick_d = tick_q + 4'd1;
                    // Mid start bit: a line that is already high again was a glitch
                    if (tick_q == 4'd7) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        // Line order is LSB first, so the newest bit enters at the top
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BCW'(1);
                        end
                    end
                end
                STOP: begin
                    tick_d = tick_q + 4'd1;
                    // Re-arm at mid stop bit so back-to-back frames are caught
                    if (tick_q == 4'd15) begin
                        tick_d     = '0;
                        state_d    = IDLE;
                        frame_good = rx_s_q;
                        frame_bad  = !rx_s_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Holding register: a pop in the same clock as a delivery frees the slot
    always_comb begin
        load    = frame_good && (!valid_q || rx_ready);
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        ferr_d = frame_bad;
        ovr_d  = frame_good && valid_q && !rx_ready;
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign framing_err = ferr_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule
